// File: rtl/rope_map_client.sv
// Map-RAM client for one player's rope: on grab, read the map slot under the rope tip and claim the item if present.
// Latency: read_req 1 cycle after grab; done 3 cycles after read_done (miss) or 2 cycles after write_done (hit).
// Backpressure: requests are held stable until the arbiter pulses read_done/write_done; grab is ignored while busy.
//
// Ports:
//   clock, resetn          rising-edge clock, synchronous active-low reset
//   grab, rope_index       grab command and map slot to fetch (sampled together, only when idle)
//   read_req, write_req    requests to the map RAM arbiter (never both high)
//   address, write_data    request address and write-back data (item with its present flag cleared)
//   read_done, write_done  arbiter completion pulses; map_data is valid with read_done
//   busy, done             transaction in progress / one-cycle completion pulse
//   hit, item              item claimed / entry as read (pre-clear); held until the next grab
//   err                    timeout abort flag
//
// Optional feature: define ROPE_MAP_CLIENT_TIMEOUT_EN to abort a READ or WRITE that has waited
// 255 cycles without its done pulse. Without it the client waits indefinitely and err is tied low.
module rope_map_client #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 32,
    parameter int PRESENT_BIT = 31
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              grab,
    input  logic [ADDR_W-1:0] rope_index,
    output logic              read_req,
    output logic              write_req,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic              read_done,
    input  logic              write_done,
    input  logic [DATA_W-1:0] map_data,
    output logic              busy,
    output logic              done,
    output logic              hit,
    output logic [DATA_W-1:0] item,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_WRITE,
        S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic                read_req_q, read_req_d;
    logic                write_req_q, write_req_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                hit_q, hit_d;
    logic [DATA_W-1:0]   item_q, item_d;
`ifdef ROPE_MAP_CLIENT_TIMEOUT_EN
    logic                err_q, err_d;
    logic [7:0]          cnt_q, cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        read_req_d   = read_req_q;
        write_req_d  = write_req_q;
        address_d    = address_q;
        write_data_d = write_data_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        hit_d        = hit_q;
        item_d       = item_q;
`ifdef ROPE_MAP_CLIENT_TIMEOUT_EN
        err_d        = err_q;
        cnt_d        = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grab) begin
                    address_d  = rope_index;
                    read_req_d = 1'b1;
                    busy_d     = 1'b1;
                    hit_d      = 1'b0;
                    state_d    = S_READ;
`ifdef ROPE_MAP_CLIENT_TIMEOUT_EN
                    err_d      = 1'b0;
                    cnt_d      = 8'd0;
`endif
                end
            end
            S_READ: begin
                if (read_done) begin
                    item_d     = map_data;
                    read_req_d = 1'b0;
                    state_d    = S_CHECK;
`ifdef ROPE_MAP_CLIENT_TIMEOUT_EN
                end else if (cnt_q == 8'd254) begin
                    // 255th waiting cycle: give up and report through FIN.
                    read_req_d = 1'b0;
                    err_d      = 1'b1;
                    hit_d      = 1'b0;
                    state_d    = S_FIN;
                end else begin
                    cnt_d      = cnt_q + 8'd1;
`endif
                end
            end
            S_CHECK: begin
                if (item_q[PRESENT_BIT]) begin
                    // Claim the item: write back the same entry with only its present flag cleared.
                    write_data_d              = item_q;
                    write_data_d[PRESENT_BIT] = 1'b0;
                    write_req_d               = 1'b1;
                    state_d                   = S_WRITE;
`ifdef ROPE_MAP_CLIENT_TIMEOUT_EN
                    cnt_d                     = 8'd0;
`endif
                end else begin
                    hit_d   = 1'b0;
                    state_d = S_FIN;
                end
            end
            S_WRITE: begin
                if (write_done) begin
                    write_req_d = 1'b0;
                    hit_d       = 1'b1;
                    state_d     = S_FIN;
`ifdef ROPE_MAP_CLIENT_TIMEOUT_EN
                end else if (cnt_q == 8'd254) begin
                    write_req_d = 1'b0;
                    err_d       = 1'b1;
                    hit_d       = 1'b0;
                    state_d     = S_FIN;
                end else begin
                    cnt_d       = cnt_q + 8'd1;
`endif
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            read_req_q   <= 1'b0;
            write_req_q  <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hit_q        <= 1'b0;
            item_q       <= '0;
`ifdef ROPE_MAP_CLIENT_TIMEOUT_EN
            err_q        <= 1'b0;
            cnt_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            read_req_q   <= read_req_d;
            write_req_q  <= write_req_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            hit_q        <= hit_d;
            item_q       <= item_d;
`ifdef ROPE_MAP_CLIENT_TIMEOUT_EN
            err_q        <= err_d;
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign read_req   = read_req_q;
    assign write_req  = write_req_q;
    assign address    = address_q;
    assign write_data = write_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign hit        = hit_q;
    assign item       = item_q;
`ifdef ROPE_MAP_CLIENT_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: doc/rope_map_client.md
ROPE_MAP_CLIENT -- requirements
Module: rope_map_client

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, map entry address width.
REQ-002 SHALL have parameter DATA_W, default 32, map entry data width.
REQ-003 SHALL have parameter PRESENT_BIT, default 31, index of the item-present flag in a map entry.
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port grab  input  1  single-cycle grab command from the player rope FSM.
REQ-007 SHALL have port rope_index  input  ADDR_W  map slot under the rope tip, sampled with grab.
REQ-008 SHALL have port read_req  output  1  read request to map RAM arbiter (this player's bit of read_req_code).
REQ-009 SHALL have port write_req  output  1  write request to map RAM arbiter (this player's bit of write_req_code).
REQ-010 SHALL have port address  output  ADDR_W  request address to the arbiter.
REQ-011 SHALL have port write_data  output  DATA_W  write-back data to the arbiter.
REQ-012 SHALL have port read_done  input  1  arbiter read-complete pulse; map_data valid in the same cycle.
REQ-013 SHALL have port write_done  input  1  arbiter write-complete pulse.
REQ-014 SHALL have port map_data  input  DATA_W  arbiter read data.
REQ-015 SHALL have port busy  output  1  transaction in progress.
REQ-016 SHALL have port done  output  1  one-cycle completion pulse.
REQ-017 SHALL have port hit  output  1  item was present and has been claimed; valid while done=1, held until next grab.
REQ-018 SHALL have port item  output  DATA_W  entry read from map (pre-clear), valid while done=1, held until next grab.
REQ-019 SHALL have port err  output  1  timeout abort flag (0 when macro absent).

Function
REQ-020 SHALL implement states IDLE, READ, CHECK, WRITE, FIN with all outputs registered.
REQ-021 SHALL in IDLE on grab=1 latch rope_index into address, set read_req=1, busy=1, enter READ (read_req visible 1 cycle after grab).
REQ-022 SHALL ignore grab whenever busy=1.
REQ-023 SHALL hold read_req and address stable in READ until read_done=1, then capture map_data into item, clear read_req, enter CHECK.
REQ-024 SHALL in CHECK, if item[PRESENT_BIT]=1, drive write_data = item with PRESENT_BIT cleared, set write_req=1, enter WRITE; else set hit=0, enter FIN.
REQ-025 SHALL hold write_req, address, write_data stable in WRITE until write_done=1, then clear write_req, set hit=1, enter FIN.
REQ-026 SHALL in FIN assert done=1 for exactly one cycle, clear busy, return to IDLE.
REQ-027 SHALL never assert read_req and write_req simultaneously.
REQ-028 SHALL ignore read_done outside READ and write_done outside WRITE.
REQ-029 SHALL deassert a request the cycle after its done pulse, so the arbiter (one START cycle before re-arbitration) never sees a stale request.

Reset
REQ-030 SHALL on resetn=0 at a clock edge force state IDLE, read_req=0, write_req=0, address=0, write_data=0, busy=0, done=0, hit=0, item=0, err=0.
REQ-031 SHALL abandon any in-flight transaction on reset without issuing further requests; late done pulses then fall under REQ-028.

Configuration
REQ-032 SHALL with ROPE_MAP_CLIENT_TIMEOUT_EN defined count cycles in READ/WRITE with an 8-bit counter, and on reaching 255 without the matching done drop the request, set err=1, hit=0, enter FIN; err cleared on next accepted grab.
REQ-033 SHALL without ROPE_MAP_CLIENT_TIMEOUT_EN wait indefinitely in READ/WRITE and tie err to 0.

Verification
REQ-034 SHALL cover hit: grab, rope_index=5, read_done after 3 cycles with map_data=0x8000_00A3 -> write_req with address=5, write_data=0x0000_00A3; after write_done, done=1, hit=1, item=0x8000_00A3.
REQ-035 SHALL cover miss: map_data=0x0000_0042 -> no write_req, done=1 with hit=0, item=0x0000_0042, 3 cycles after read_done.
REQ-036 SHALL cover grab while busy: second grab with rope_index=9 during READ -> ignored, address stays 5, only one done pulse.
REQ-037 SHALL cover reset mid-WRITE: resetn=0 one cycle -> all outputs 0 next edge; subsequent write_done produces no done.
REQ-038 SHALL cover timeout (macro defined): read_done never arrives -> read_req drops after 255 cycles, done=1, err=1, hit=0; next grab clears err.
REQ-039 SHALL cover stray pulses: read_done/write_done in IDLE -> no output change.
